// File: rtl/ctu_clsp_synch_cldl_pkg.sv
// Shared widths, limits and pulse-FSM encoding for the CTU cmp-to-DRAM launch block.
package ctu_clsp_synch_cldl_pkg;

    localparam int unsigned RATIO_W   = 5;
    localparam int unsigned NUM_CKEN  = 6;
    localparam int unsigned RATIO_MIN = 2;

    typedef enum logic [1:0] {
        PS_IDLE   = 2'd0,
        PS_PEND   = 2'd1,
        PS_ACTIVE = 2'd2
    } pulse_state_e;

endpackage

// File: rtl/ctu_clsp_synch_cldl_dsync_gen.sv
// Ratio counter with clamped ratio latch; emits a registered one-cycle DRAM sync edge pulse.
module ctu_clsp_dsync_gen
    import ctu_clsp_synch_cldl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [RATIO_W-1:0] ratio,
    output logic               dsync_edge
);

    logic [RATIO_W-1:0] cnt;
    logic [RATIO_W-1:0] rl;
    logic               term_c;
    logic [RATIO_W-1:0] ratio_clamped_c;

    // The edge flop trails the terminal count by one cycle, so the counter reads 0 on the edge cycle.
    assign term_c          = (cnt == rl - RATIO_W'(1));
    assign ratio_clamped_c = (ratio < RATIO_W'(RATIO_MIN)) ? RATIO_W'(RATIO_MIN) : ratio;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            rl         <= RATIO_W'(RATIO_MIN);
            dsync_edge <= 1'b0;
        end else begin
            cnt        <= term_c ? '0 : cnt + RATIO_W'(1);
            dsync_edge <= term_c;
            if (dsync_edge) begin
                rl <= ratio_clamped_c;
            end
        end
    end

endmodule

// File: rtl/ctu_clsp_synch_cldl.sv
// Launches CTU cken/start_clk levels and grst/dbginit pulses into the DRAM domain on the sync edge.
module ctu_clsp_synch_cldl
    import ctu_clsp_synch_cldl_pkg::*;
(
    input  logic                cmp_gclk,
    input  logic                io_pwron_rst_l,
    input  logic [RATIO_W-1:0]  ratio,
    input  logic [NUM_CKEN-1:0] cken_req,
    input  logic                start_clk_req,
    input  logic                grst_req,
    input  logic                dbginit_req,
    output logic                dsync_edge,
    output logic [NUM_CKEN-1:0] cken_dl,
    output logic                start_clk_dl,
    output logic                a_grst_dl,
    output logic                a_dbginit_dl,
    output logic                de_grst_dsync_edge_dl,
    output logic                de_dbginit_dsync_edge_dl,
    output logic                grst_ack,
    output logic                dbginit_ack
);

    pulse_state_e grst_st, grst_nx;
    pulse_state_e dbg_st, dbg_nx;
    logic         grst_busy_c;

    ctu_clsp_dsync_gen u_dsync_gen (
        .clk        (cmp_gclk),
        .rst_n      (io_pwron_rst_l),
        .ratio      (ratio),
        .dsync_edge (dsync_edge)
    );

    // A grst request or an in-flight grst pre-empts any pending dbginit.
    assign grst_busy_c = grst_req || (grst_st != PS_IDLE);

    always_comb begin
        grst_nx = grst_st;
        unique case (grst_st)
            PS_IDLE:   if (grst_req)   grst_nx = PS_PEND;
            PS_PEND:   if (dsync_edge) grst_nx = PS_ACTIVE;
            PS_ACTIVE: if (dsync_edge) grst_nx = PS_IDLE;
            default:                   grst_nx = PS_IDLE;
        endcase
    end

    always_comb begin
        dbg_nx = dbg_st;
        unique case (dbg_st)
            PS_IDLE:   if (dbginit_req && !grst_busy_c) dbg_nx = PS_PEND;
            PS_PEND: begin
                if (grst_busy_c)     dbg_nx = PS_IDLE;
                else if (dsync_edge) dbg_nx = PS_ACTIVE;
            end
            PS_ACTIVE: if (dsync_edge) dbg_nx = PS_IDLE;
            default:                   dbg_nx = PS_IDLE;
        endcase
    end

    always_ff @(posedge cmp_gclk or negedge io_pwron_rst_l) begin
        if (!io_pwron_rst_l) begin
            grst_st <= PS_IDLE;
            dbg_st  <= PS_IDLE;
        end else begin
            grst_st <= grst_nx;
            dbg_st  <= dbg_nx;
        end
    end

    // Level launch: sample on the sync edge, hold for the full DRAM period.
    always_ff @(posedge cmp_gclk or negedge io_pwron_rst_l) begin
        if (!io_pwron_rst_l) begin
            cken_dl      <= '0;
            start_clk_dl <= 1'b0;
        end else if (dsync_edge) begin
            cken_dl      <= cken_req;
            start_clk_dl <= start_clk_req;
        end
    end

    always_ff @(posedge cmp_gclk or negedge io_pwron_rst_l) begin
        if (!io_pwron_rst_l) begin
            a_grst_dl                <= 1'b0;
            a_dbginit_dl             <= 1'b0;
            de_grst_dsync_edge_dl    <= 1'b0;
            de_dbginit_dsync_edge_dl <= 1'b0;
            grst_ack                 <= 1'b0;
            dbginit_ack              <= 1'b0;
        end else begin
            a_grst_dl                <= (grst_nx == PS_ACTIVE);
            a_dbginit_dl             <= (dbg_nx == PS_ACTIVE);
            de_grst_dsync_edge_dl    <= (grst_st == PS_PEND) && (grst_nx == PS_ACTIVE);
            de_dbginit_dsync_edge_dl <= (dbg_st == PS_PEND) && (dbg_nx == PS_ACTIVE);
            grst_ack                 <= (grst_st == PS_PEND) && (grst_nx == PS_ACTIVE);
            dbginit_ack              <= (dbg_st == PS_PEND) && (dbg_nx == PS_ACTIVE);
        end
    end

endmodule
